// File: rtl/my_alu_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : my_alu_sequencer_pkg
// Brief    : ISA opcodes, instruction field positions, FSM states and field
//            extraction helpers shared by the sequencer and the ALU decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package my_alu_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b0000;

    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 3;
    localparam int RD_LSB  = 4;
    localparam int RD_MSB  = 6;
    localparam int RS_LSB  = 7;
    localparam int RS_MSB  = 9;
    localparam int IMM_LSB = 10;
    localparam int IMM_MSB = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] ir_op(input logic [15:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] ir_rd(input logic [15:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [2:0] ir_rs(input logic [15:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [15:0] ir_imm(input logic [15:0] ir);
        return {10'd0, ir[IMM_MSB:IMM_LSB]};
    endfunction

    // Undefined opcodes fall through as counted NOPs.
    function automatic logic op_writes(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic op_sets_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/my_alu_decoder.sv
//------------------------------------------------------------------------------
// Module   : my_alu_decoder
// Brief    : Combinational ALU; decodes the opcode of ir and combines a and b.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module my_alu_decoder
    import my_alu_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] r,
    output logic        cout
);

    logic [16:0] w_sum;
    logic        w_unused_ir;

    assign w_sum       = {1'b0, a} + {1'b0, b};
    assign w_unused_ir = ^ir[15:4];

    always_comb begin
        r    = a;
        cout = w_sum[16];
        case (ir_op(ir))
            OP_ADD, OP_ADDI: r = w_sum[15:0];
            OP_AND:          r = a & b;
            OP_OR:           r = a | b;
            OP_XOR:          r = a ^ b;
            OP_NOT:          r = ~a;
            default:         r = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/my_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : my_alu_sequencer
// Brief    : Three-cycle fetch/load/exec sequencer with an 8x16 register file,
//            carry flag and retired-instruction counter around my_alu_decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module my_alu_sequencer
    import my_alu_sequencer_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int NREG    = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_data,
    output logic               busy,
    output logic               done,
    output logic               carry,
    output logic [15:0]        icount,
    input  logic [2:0]         dbg_sel,
    output logic [15:0]        dbg_data
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IMEM_AW-1:0] r_pc;
    logic [15:0]        r_ir;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [15:0]        r_regs [NREG];
    logic               r_carry;
    logic [15:0]        r_icount;
    logic [15:0]        w_r;
    logic               w_cout;
    logic               w_halt;

    assign w_halt = (ir_op(r_ir) == OP_HALT);

    my_alu_decoder u_alu (
        .ir   (r_ir),
        .a    (r_a),
        .b    (r_b),
        .r    (w_r),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_halt ? S_DONE : S_FETCH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Writeback, carry, icount and pc all commit on the same EXEC edge, so the
    // following LOAD reads the updated register file without forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_icount <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_pc <= '0;
                end
                S_LOAD: begin
                    r_ir <= imem_data;
                    r_a  <= r_regs[ir_rd(imem_data)];
                    r_b  <= (ir_op(imem_data) == OP_ADDI) ? ir_imm(imem_data)
                                                          : r_regs[ir_rs(imem_data)];
                end
                S_EXEC: begin
                    if (!w_halt) begin
                        if (op_writes(ir_op(r_ir)))     r_regs[ir_rd(r_ir)] <= w_r;
                        if (op_sets_carry(ir_op(r_ir))) r_carry <= w_cout;
                        r_icount <= r_icount + 16'd1;
                        r_pc     <= r_pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign busy      = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_EXEC);
    assign done      = (r_state == S_DONE);
    assign carry     = r_carry;
    assign icount    = r_icount;
    assign dbg_data  = r_regs[dbg_sel];

endmodule

`default_nettype wire

// File: tb/tb_my_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_my_alu_sequencer
// Brief    : Directed self-checking bench: table of programs truncated by a
//            HALT, plus cycle-exact timing, PC-wrap and async-reset sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_my_alu_sequencer;

    localparam logic [3:0] c_op_add  = 4'b1010;
    localparam logic [3:0] c_op_addi = 4'b1001;
    localparam logic [3:0] c_op_and  = 4'b1100;
    localparam logic [3:0] c_op_or   = 4'b1110;
    localparam logic [3:0] c_op_xor  = 4'b0110;
    localparam logic [3:0] c_op_not  = 4'b1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'd0;
    logic        busy;
    logic        done;
    logic        carry;
    logic [15:0] icount;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_data;

    logic [15:0] rom [256];
    logic [15:0] progs [3][16];

    typedef struct {
        int          prog;
        int          stop;
        logic [2:0]  rsel;
        logic [15:0] exp_val;
        logic        exp_carry;
        logic [15:0] exp_ic;
    } vec_t;

    vec_t vecs [14];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    my_alu_sequencer #(
        .IMEM_AW (8),
        .NREG    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .busy      (busy),
        .done      (done),
        .carry     (carry),
        .icount    (icount),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] imm);
        return {imm, rs, rd, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic peek(input logic [2:0] sel, output logic [15:0] val);
        dbg_sel = sel;
        #1;
        val = dbg_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_prog(input int p, input int stop);
        for (int j = 0; j < 256; j++) begin
            if (j < stop) rom[j] = progs[p][j];
            else          rom[j] = 16'h0000;
        end
    endtask

    // Returns the cycle number (cycle 1 = first FETCH) in which done is seen.
    task automatic run_to_done(input int limit, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [15:0] v;
        int          cyc;

        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 16; j++) progs[k][j] = 16'h0000;

        for (int k = 0; k < 4; k++) begin
            progs[0][k] = enc(c_op_addi, 3'd2, 3'd0, 6'd63);
            progs[1][k] = enc(c_op_addi, 3'd2, 3'd0, 6'd63);
        end
        progs[0][4]  = enc(c_op_addi, 3'd2, 3'd0, 6'd3);
        progs[0][5]  = enc(c_op_or,   3'd1, 3'd2, 6'd0);
        progs[0][6]  = enc(c_op_not,  3'd1, 3'd5, 6'd0);
        progs[0][7]  = enc(c_op_addi, 3'd2, 3'd0, 6'd2);
        progs[0][8]  = enc(c_op_add,  3'd1, 3'd2, 6'd0);

        progs[1][4]  = enc(c_op_addi, 3'd2, 3'd0, 6'd3);
        progs[1][5]  = enc(c_op_or,   3'd1, 3'd2, 6'd0);
        progs[1][6]  = enc(c_op_not,  3'd1, 3'd0, 6'd0);
        progs[1][7]  = enc(c_op_not,  3'd3, 3'd0, 6'd0);
        progs[1][8]  = enc(c_op_addi, 3'd3, 3'd0, 6'd1);
        progs[1][9]  = enc(c_op_and,  3'd1, 3'd2, 6'd0);
        progs[1][10] = enc(c_op_or,   3'd1, 3'd2, 6'd0);
        progs[1][11] = enc(c_op_xor,  3'd2, 3'd2, 6'd0);
        progs[1][12] = enc(c_op_not,  3'd2, 3'd0, 6'd0);
        progs[1][13] = 16'h0005;

        progs[2][0]  = 16'h4019;
        progs[2][1]  = 16'h2419;

        //           prog stop reg    value       carry  icount
        vecs[0]  = '{2, 2,  3'd1, 16'd25,     1'b0, 16'd2};
        vecs[1]  = '{2, 1,  3'd1, 16'd16,     1'b0, 16'd1};
        vecs[2]  = '{0, 5,  3'd2, 16'h00FF,   1'b0, 16'd5};
        vecs[3]  = '{0, 8,  3'd1, 16'hFF00,   1'b0, 16'd8};
        vecs[4]  = '{0, 9,  3'd1, 16'h0001,   1'b1, 16'd9};
        vecs[5]  = '{0, 9,  3'd2, 16'h0101,   1'b1, 16'd9};
        vecs[6]  = '{1, 9,  3'd1, 16'hFF00,   1'b1, 16'd9};
        vecs[7]  = '{1, 9,  3'd3, 16'h0000,   1'b1, 16'd9};
        vecs[8]  = '{1, 10, 3'd1, 16'h0000,   1'b1, 16'd10};
        vecs[9]  = '{1, 11, 3'd1, 16'h00FF,   1'b1, 16'd11};
        vecs[10] = '{1, 12, 3'd2, 16'h0000,   1'b1, 16'd12};
        vecs[11] = '{1, 13, 3'd2, 16'hFFFF,   1'b1, 16'd13};
        vecs[12] = '{1, 14, 3'd2, 16'hFFFF,   1'b1, 16'd14};
        vecs[13] = '{1, 14, 3'd1, 16'h00FF,   1'b1, 16'd14};

        for (int j = 0; j < 256; j++) rom[j] = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_carry",     {31'd0, carry},     32'd0);
        chk("rst_icount",    {16'd0, icount},    32'd0);
        for (int r = 0; r < 8; r++) begin
            peek(3'(r), v);
            chk($sformatf("rst_r%0d", r), {16'd0, v}, 32'd0);
        end

        // Table-driven programs
        for (int i = 0; i < 14; i++) begin
            do_reset();
            load_prog(vecs[i].prog, vecs[i].stop);
            run_to_done(300, cyc);
            peek(vecs[i].rsel, v);
            chk($sformatf("vec%0d_r%0d", i, vecs[i].rsel), {16'd0, v}, {16'd0, vecs[i].exp_val});
            chk($sformatf("vec%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].exp_carry});
            chk($sformatf("vec%0d_icount", i), {16'd0, icount}, {16'd0, vecs[i].exp_ic});
            chk($sformatf("vec%0d_done_cycle", i), 32'(cyc), 32'(3 * vecs[i].stop + 4));
        end

        // Cycle-exact ADDI chain with a start pulse while busy
        do_reset();
        load_prog(2, 2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("busy_c%0d", c), {31'd0, busy}, {31'd0, (c <= 9)});
            chk($sformatf("done_c%0d", c), {31'd0, done}, {31'd0, (c == 10)});
            if (c == 4) begin
                chk("pc_c4", {24'd0, imem_addr}, 32'd1);
                start = 1'b1;
            end
            if (c == 5) start = 1'b0;
            if (c == 10) begin
                chk("timing_icount", {16'd0, icount}, 32'd2);
                peek(3'd1, v);
                chk("timing_r1", {16'd0, v}, 32'd25);
            end
            @(posedge clk);
            #1;
        end

        // PC wrap: NOPs everywhere, HALT patched into address 0 after the first pass starts
        do_reset();
        for (int j = 0; j < 256; j++) rom[j] = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            if (cyc == 30) rom[0] = 16'h0000;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("wrap_done_seen", {31'd0, done}, 32'd1);
        chk("wrap_done_cycle", 32'(cyc), 32'd772);
        chk("wrap_icount", {16'd0, icount}, 32'd256);
        chk("wrap_pc", {24'd0, imem_addr}, 32'd0);
        chk("wrap_carry", {31'd0, carry}, 32'd0);
        peek(3'd1, v);
        chk("wrap_r1", {16'd0, v}, 32'd0);

        // Asynchronous reset during the EXEC of ADDI r1,#16
        do_reset();
        load_prog(2, 2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, busy},      32'd0);
        chk("arst_done",   {31'd0, done},      32'd0);
        chk("arst_carry",  {31'd0, carry},     32'd0);
        chk("arst_icount", {16'd0, icount},    32'd0);
        chk("arst_addr",   {24'd0, imem_addr}, 32'd0);
        peek(3'd1, v);
        chk("arst_r1", {16'd0, v}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_idle_busy", {31'd0, busy}, 32'd0);
        peek(3'd1, v);
        chk("arst_no_wb_r1", {16'd0, v}, 32'd0);
        run_to_done(300, cyc);
        peek(3'd1, v);
        chk("rerun_r1", {16'd0, v}, 32'd25);
        chk("rerun_icount", {16'd0, icount}, 32'd2);
        chk("rerun_cycle", 32'(cyc), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
